join_any_race: RTL and testbench
================================

Name: join_any_race

Overview:
- Hardware analog of a fork/join_any construct.
- On a start request, N_THREADS independent countdown "threads" are launched in parallel, each with its own programmed delay and payload value.
- The block signals the first completion (join_any) with the winner's index and value, so a downstream controller can proceed.
- The remaining threads keep running to completion and report individually; a final all-complete event closes the operation.

Parameters:
- N_THREADS, 3, number of parallel threads (1..16).
- DELAY_W, 5, width of each per-thread delay, in clock cycles.
- VALUE_W, 5, width of each per-thread payload value.
- TIME_W, 16, width of the elapsed-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch request; accepted only when busy=0.
- delay_i  in  N_THREADS*DELAY_W  per-thread delays; thread i at bits [i*DELAY_W +: DELAY_W].
- value_i  in  N_THREADS*VALUE_W  per-thread payloads, same packing as delay_i.
- busy  out  1  high from acceptance until all threads have completed.
- thread_done  out  N_THREADS  one-cycle pulse per thread at its completion.
- thread_value  out  N_THREADS*VALUE_W  latched payload of each thread; valid from its completion pulse until the next accept.
- any_done  out  1  one-cycle pulse at the first completion of an operation.
- any_idx  out  clog2(N_THREADS), min 1  index of the winning thread; held until next accept.
- any_value  out  VALUE_W  payload of the winning thread; held until next accept.
- all_done  out  1  one-cycle pulse when the last thread completes.
- time_o  out  TIME_W  cycles elapsed since the accepting edge; saturates at all-ones.

Behaviour:
- Reset: all outputs 0 (busy, thread_done, thread_value, any_done, any_idx, any_value, all_done, time_o); all counters and flags cleared.
- Reset mid-operation aborts all threads. No done pulses follow until the next accepted start.
- Accept:
  - On a rising edge with start=1 and busy=0 (edge T0), all delay_i and value_i are captured into per-thread registers.
  - busy goes 1 after T0; time_o goes to 0 at T0, then increments by 1 each edge.
  - thread_value, any_idx and any_value are cleared at T0.
- start while busy=1 is ignored; it has no effect on any running thread.
- Thread completion timing: thread i completes at edge T0+max(d_i,1).
  - thread_done[i] is high for exactly that one cycle.
  - thread_value[i] is loaded with the thread's payload on that same edge.
  - time_o equals max(d_i,1) during the pulse.
  - A delay of 0 behaves identically to a delay of 1.
- join_any:
  - any_done pulses once per operation, in the cycle of the earliest thread completion.
  - any_idx/any_value latch the winner on that edge.
  - Simultaneous earliest completions: the lowest index wins. All tied threads still pulse their thread_done bits in the same cycle.
  - Later completions never re-trigger any_done or alter any_idx/any_value.
- join (all):
  - all_done pulses in the cycle of the last completion; busy falls on that same edge.
  - If all delays are equal, any_done, all_done and every thread_done bit pulse together.
- Back-to-back: start may be high in the cycle all_done is asserted. busy=0 is then seen at the next edge and a new operation is accepted there.
- time_o holds its final value after completion until the next accept; it saturates at all-ones and never wraps.
- Fully synchronous design: single clock, no combinational path from inputs to outputs.

Test Plan:
- Reset check: hold rst 3 cycles, including one edge with start=1 -> all outputs 0, busy=0, start ignored.
- Basic race: delays {7,5,2}, values {10,8,4}, start=1 at T0 ->
  - edge T0+2: any_done, any_idx=2, any_value=4, thread_done=3'b100, time_o=2.
  - edge T0+5: thread_done[1], thread_value[1]=8.
  - edge T0+7: thread_done[0], all_done, busy falls.
- Tie and zero delay: delays {3,0,1}, values {1,2,3} ->
  - edge T0+1: any_done, any_idx=1, any_value=2, thread_done=3'b110.
  - edge T0+3: all_done.
- Long delays: delays {20,30,10}, values {5,6,7} -> any_done at T0+10 with any_idx=2; thread 0 at T0+20; all_done at T0+30.
- Busy and back-to-back: pulse start at T0+4 during the basic race -> ignored, timing unchanged; hold start high through all_done -> new accept on the following edge, any_idx/any_value/thread_value cleared.
- Reset mid-operation: assert rst at T0+3 of the basic race -> no further thread_done/any_done/all_done pulses, busy=0, time_o=0.

Source files
------------

// File: rtl/join_any_race.sv
// join_any_race: launches N_THREADS countdown threads on an accepted start and
// reports the first completion (join_any), each thread's own completion, and
// the final completion of all threads (join).
module join_any_race #(
  parameter int N_THREADS = 3,
  parameter int DELAY_W   = 5,
  parameter int VALUE_W   = 5,
  parameter int TIME_W    = 16,
  localparam int IDX_W    = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N_THREADS*DELAY_W-1:0]   delay_i,
  input  logic [N_THREADS*VALUE_W-1:0]   value_i,
  output logic                           busy,
  output logic [N_THREADS-1:0]           thread_done,
  output logic [N_THREADS*VALUE_W-1:0]   thread_value,
  output logic                           any_done,
  output logic [IDX_W-1:0]               any_idx,
  output logic [VALUE_W-1:0]             any_value,
  output logic                           all_done,
  output logic [TIME_W-1:0]              time_o
);

  // Per-thread state
  logic [DELAY_W-1:0]   remaining_reg [N_THREADS];
  logic [VALUE_W-1:0]   payload_reg   [N_THREADS];
  logic [VALUE_W-1:0]   result_reg    [N_THREADS];
  logic [DELAY_W-1:0]   load_delay    [N_THREADS];
  logic [N_THREADS-1:0] running_reg;
  logic [N_THREADS-1:0] thread_done_reg;
  logic [N_THREADS-1:0] done_now;

  // Operation-level state
  logic                 busy_reg;
  logic                 any_seen_reg;
  logic                 any_done_reg;
  logic                 all_done_reg;
  logic [IDX_W-1:0]     any_idx_reg;
  logic [VALUE_W-1:0]   any_value_reg;
  logic [TIME_W-1:0]    time_reg;

  logic                 accept;
  logic                 finish_now;
  logic [IDX_W-1:0]     win_idx;
  logic [VALUE_W-1:0]   win_value;

  assign accept = start && !busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_THREADS; gi++) begin : g_thread
      // A zero delay is treated as one cycle so every thread completes after T0.
      assign load_delay[gi] = (delay_i[gi*DELAY_W +: DELAY_W] == '0)
                              ? DELAY_W'(1) : delay_i[gi*DELAY_W +: DELAY_W];
      // Thread completes on the edge where its remaining count is 1.
      assign done_now[gi] = busy_reg && running_reg[gi]
                            && (remaining_reg[gi] == DELAY_W'(1));
      assign thread_value[gi*VALUE_W +: VALUE_W] = result_reg[gi];
    end
  endgenerate

  // Last completion: something finishes now and nothing keeps running after.
  assign finish_now = (|done_now) && ((running_reg & ~done_now) == '0);

  // Pick the lowest-index completing thread as the join_any winner.
  always_comb begin
    win_idx   = '0;
    win_value = '0;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      if (done_now[i]) begin
        win_idx   = IDX_W'(i);
        win_value = payload_reg[i];
      end
    end
  end

  // Per-thread countdowns, captured payloads and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_reg     <= '0;
      thread_done_reg <= '0;
      for (int i = 0; i < N_THREADS; i++) begin
        remaining_reg[i] <= '0;
        payload_reg[i]   <= '0;
        result_reg[i]    <= '0;
      end
    end else begin
      thread_done_reg <= '0;
      if (accept) begin
        running_reg <= '1;
        for (int i = 0; i < N_THREADS; i++) begin
          remaining_reg[i] <= load_delay[i];
          payload_reg[i]   <= value_i[i*VALUE_W +: VALUE_W];
          result_reg[i]    <= '0;
        end
      end else begin
        for (int i = 0; i < N_THREADS; i++) begin
          if (done_now[i]) begin
            thread_done_reg[i] <= 1'b1;
            result_reg[i]      <= payload_reg[i];
            running_reg[i]     <= 1'b0;
          end else if (busy_reg && running_reg[i]) begin
            remaining_reg[i] <= remaining_reg[i] - DELAY_W'(1);
          end
        end
      end
    end
  end

  // Operation control: busy, elapsed time, join_any latch and join pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= 1'b0;
      any_seen_reg  <= 1'b0;
      any_done_reg  <= 1'b0;
      all_done_reg  <= 1'b0;
      any_idx_reg   <= '0;
      any_value_reg <= '0;
      time_reg      <= '0;
    end else begin
      any_done_reg <= 1'b0;
      all_done_reg <= 1'b0;
      if (accept) begin
        busy_reg      <= 1'b1;
        any_seen_reg  <= 1'b0;
        any_idx_reg   <= '0;
        any_value_reg <= '0;
        time_reg      <= '0;
      end else if (busy_reg) begin
        if (!(&time_reg)) begin
          time_reg <= time_reg + TIME_W'(1);
        end
        if ((|done_now) && !any_seen_reg) begin
          any_seen_reg  <= 1'b1;
          any_done_reg  <= 1'b1;
          any_idx_reg   <= win_idx;
          any_value_reg <= win_value;
        end
        if (finish_now) begin
          all_done_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      end
    end
  end

  assign busy        = busy_reg;
  assign thread_done = thread_done_reg;
  assign any_done    = any_done_reg;
  assign any_idx     = any_idx_reg;
  assign any_value   = any_value_reg;
  assign all_done    = all_done_reg;
  assign time_o      = time_reg;

endmodule

// File: tb/tb_join_any_race.sv
// Scoreboard bench for join_any_race: stimulus pushes the expected completion
// events, a negedge monitor pops and compares whenever a done pulse appears.
module tb_join_any_race;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] delay_i;
  logic [14:0] value_i;
  logic        busy;
  logic [2:0]  thread_done;
  logic [14:0] thread_value;
  logic        any_done;
  logic [1:0]  any_idx;
  logic [4:0]  any_value;
  logic        all_done;
  logic [15:0] time_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  td;
    logic        any;
    logic [1:0]  idx;
    logic [4:0]  av;
    logic        all;
    logic [15:0] t;
    logic [14:0] tv;
  } ev_t;

  ev_t exp_q[$];

  join_any_race dut (
    .clk(clk), .rst(rst), .start(start), .delay_i(delay_i), .value_i(value_i),
    .busy(busy), .thread_done(thread_done), .thread_value(thread_value),
    .any_done(any_done), .any_idx(any_idx), .any_value(any_value),
    .all_done(all_done), .time_o(time_o)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input int a0, input int a1, input int a2);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_ev(input logic [2:0] td, input logic any, input int idx, input int av,
                         input logic all, input int t, input logic [14:0] tv);
    ev_t e;
    e.td = td; e.any = any; e.idx = 2'(idx); e.av = 5'(av);
    e.all = all; e.t = 16'(t); e.tv = tv;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int d0, input int d1, input int d2,
                        input int v0, input int v1, input int v2);
    delay_i = {5'(d2), 5'(d1), 5'(d0)};
    value_i = {5'(v2), 5'(v1), 5'(v0)};
  endtask

  // Raise start for one accepting edge (T0); returns #1 after T0.
  task automatic launch(input int d0, input int d1, input int d2,
                        input int v0, input int v1, input int v2, input bit hold);
    @(posedge clk); #1;
    set_in(d0, d1, d2, v0, v1, v2);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  // Monitor: every done pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (thread_done != 3'b0 || any_done || all_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event actual td=%b any=%b all=%b t=%0d required no event",
                 thread_done, any_done, all_done, time_o);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] event td=%b any=%b idx=%0d val=%0d all=%b t=%0d",
                 thread_done, any_done, any_idx, any_value, all_done, time_o);
        check("ev_thread_done", 32'(thread_done), 32'(e.td));
        check("ev_any_done", 32'(any_done), 32'(e.any));
        check("ev_any_idx", 32'(any_idx), 32'(e.idx));
        check("ev_any_value", 32'(any_value), 32'(e.av));
        check("ev_all_done", 32'(all_done), 32'(e.all));
        check("ev_time", 32'(time_o), 32'(e.t));
        check("ev_thread_value", 32'(thread_value), 32'(e.tv));
        check("ev_busy", 32'(busy), 32'(!e.all));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset held 3 edges with start high: everything stays at zero.
    rst = 1'b1;
    start = 1'b1;
    set_in(7, 5, 2, 10, 8, 4);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_thread_done", 32'(thread_done), 0);
    check("rst_thread_value", 32'(thread_value), 0);
    check("rst_any_done", 32'(any_done), 0);
    check("rst_any_idx", 32'(any_idx), 0);
    check("rst_any_value", 32'(any_value), 0);
    check("rst_all_done", 32'(all_done), 0);
    check("rst_time", 32'(time_o), 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 0);

    // Basic race with an ignored start pulse at T0+4.
    push_ev(3'b100, 1, 2, 4, 0, 2, pk(0, 0, 4));
    push_ev(3'b010, 0, 2, 4, 0, 5, pk(0, 8, 4));
    push_ev(3'b001, 0, 2, 4, 1, 7, pk(10, 8, 4));
    launch(7, 5, 2, 10, 8, 4, 0);
    check("basic_busy", 32'(busy), 1);
    check("basic_time0", 32'(time_o), 0);
    repeat (3) @(posedge clk);
    #1;
    set_in(1, 1, 1, 9, 9, 9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("basic_idle");
    repeat (3) @(negedge clk);
    check("basic_time_hold", 32'(time_o), 7);
    check("basic_idx_hold", 32'(any_idx), 2);
    check("basic_val_hold", 32'(any_value), 4);
    check("basic_tv_hold", 32'(thread_value), 32'(pk(10, 8, 4)));

    // Tie and zero delay.
    push_ev(3'b110, 1, 1, 2, 0, 1, pk(0, 2, 3));
    push_ev(3'b001, 0, 1, 2, 1, 3, pk(1, 2, 3));
    launch(3, 0, 1, 1, 2, 3, 0);
    wait_idle("tie_idle");

    // Long delays.
    push_ev(3'b100, 1, 2, 7, 0, 10, pk(0, 0, 7));
    push_ev(3'b001, 0, 2, 7, 0, 20, pk(5, 0, 7));
    push_ev(3'b010, 0, 2, 7, 1, 30, pk(5, 6, 7));
    launch(20, 30, 10, 5, 6, 7, 0);
    wait_idle("long_idle");

    // Back-to-back: start held through all_done, equal delays next.
    push_ev(3'b100, 1, 2, 4, 0, 2, pk(0, 0, 4));
    push_ev(3'b010, 0, 2, 4, 0, 5, pk(0, 8, 4));
    push_ev(3'b001, 0, 2, 4, 1, 7, pk(10, 8, 4));
    push_ev(3'b111, 1, 0, 1, 1, 4, pk(1, 2, 3));
    launch(7, 5, 2, 10, 8, 4, 1);
    set_in(4, 4, 4, 1, 2, 3);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (all_done) found = 1;
    end
    check("b2b_all_done_seen", 32'(found), 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("b2b_time0", 32'(time_o), 0);
    check("b2b_idx_clr", 32'(any_idx), 0);
    check("b2b_val_clr", 32'(any_value), 0);
    check("b2b_tv_clr", 32'(thread_value), 0);
    wait_idle("b2b_idle");

    // Reset mid-operation at T0+3: only the T0+2 completion is ever seen.
    push_ev(3'b100, 1, 2, 4, 0, 2, pk(0, 0, 4));
    launch(7, 5, 2, 10, 8, 4, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_time", 32'(time_o), 0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_busy_late", 32'(busy), 0);
    check("midrst_time_late", 32'(time_o), 0);
    check("midrst_any_value", 32'(any_value), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
